// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR). One register stage per shift-amount bit,
// valid/ready handshake with whole-pipe stall on backpressure.
module shift_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Shift_In,
  input  logic [SHW-1:0]   Shift_Val,
  input  logic [1:0]       Mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Shift_Out,
  output logic             Zero
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // Data and valid exist in every stage; sideband is only kept where a later stage consumes it.
  logic [WIDTH-1:0] data_p   [SHW];
  logic             vld_p    [SHW];
  logic [SHW-1:1]   amt_p    [SHW-1];
  logic [1:0]       mode_p   [SHW-1];
  logic             sign_p   [SHW-1];
  logic             zero_p;
  logic [WIDTH-1:0] data_nxt [SHW];
  logic             adv;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input logic             s,
    input logic             en,
    input int               k
  );
    logic signed [WIDTH:0]  sx;
    logic [2*WIDTH-1:0]     rot;
    int                     n;
    n   = en ? (1 << k) : 0;
    sx  = $signed({s, d}) >>> n;
    rot = {d, d} >> n;
    case (m)
      MODE_SLL: shift_step = d << n;
      MODE_SRL: shift_step = d >> n;
      MODE_SRA: shift_step = sx[WIDTH-1:0];
      default:  shift_step = rot[WIDTH-1:0];
    endcase
  endfunction

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p[SHW-1];
  assign Shift_Out = data_p[SHW-1];
  assign Zero      = zero_p;

  always_comb begin
    for (int k = 0; k < SHW; k++) data_nxt[k] = '0;
    data_nxt[0] = shift_step(Shift_In, Mode, Shift_In[WIDTH-1], Shift_Val[0], 0);
    for (int k = 1; k < SHW; k++)
      data_nxt[k] = shift_step(data_p[k-1], mode_p[k-1], sign_p[k-1], amt_p[k-1][k], k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        data_p[k] <= '0;
        vld_p[k]  <= 1'b0;
      end
      for (int k = 0; k < SHW-1; k++) begin
        amt_p[k]  <= '0;
        mode_p[k] <= '0;
        sign_p[k] <= 1'b0;
      end
      zero_p <= 1'b0;
    end else if (adv) begin
      // stage 0: operand capture, sign sampled once here for SRA
      data_p[0] <= data_nxt[0];
      vld_p[0]  <= in_valid;
      amt_p[0]  <= Shift_Val[SHW-1:1];
      mode_p[0] <= Mode;
      sign_p[0] <= Shift_In[WIDTH-1];
      // stages 1..SHW-1: each applies its power-of-two step
      for (int k = 1; k < SHW; k++) begin
        data_p[k] <= data_nxt[k];
        vld_p[k]  <= vld_p[k-1];
      end
      for (int k = 1; k < SHW-1; k++) begin
        amt_p[k]  <= amt_p[k-1];
        mode_p[k] <= mode_p[k-1];
        sign_p[k] <= sign_p[k-1];
      end
      // final stage: zero flag registered alongside the result
      zero_p <= vld_p[SHW-2] & (data_nxt[SHW-1] == '0);
    end
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined, multi-mode barrel shifter; successor to the combinational 16-bit logical-left shifter in the ALU.
- Supports SLL, SRL, SRA and ROR on a WIDTH-bit operand.
- Places one register stage per log2 shift level, so the result arrives after a fixed number of cycles.
- Uses valid/ready handshakes on input and output, with whole-pipe stall on backpressure; sits between ALU operand select and writeback.

Parameters:
- WIDTH, 16, operand width. Must be a power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  pipe can accept an operand this cycle.
- Shift_In  input  WIDTH  operand.
- Shift_Val  input  SHW  shift amount, 0..WIDTH-1.
- Mode  input  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- Shift_Out  output  WIDTH  result.
- Zero  output  1  Shift_Out == 0, qualified by out_valid.

Behaviour:
- Latency is exactly SHW cycles from input accept (in_valid & in_ready at edge) to out_valid, provided there is no stall. WIDTH=16 gives 4 cycles.
- Stage k (k = 0..SHW-1) registers the data from stage k-1, with shift 2^k applied if shift-amount bit k is set. Stage 0 takes Shift_In.
- Mode and the shift amount travel as sideband alongside the data through every stage, together with a valid bit.
- Fill rules per mode:
  - SLL: zeros fill from the LSB end.
  - SRL: zeros fill from the MSB end.
  - SRA: the original operand's bit WIDTH-1 fills from the MSB end. The sign is carried as sideband, not re-read per stage.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- Shift_Val = 0 returns the operand unchanged in every mode.
- The maximum amount WIDTH-1 is legal. There is no out-of-range encoding.
- Advance condition: adv = ~out_valid | out_ready.
  - When adv=1, all stages shift forward one position and stage 0 loads the input (valid = in_valid).
  - When adv=0, all stages, sideband and outputs hold.
- in_ready = adv, combinationally. Bubbles are not collapsed.
- Output stability: while out_valid=1 and out_ready=0, Shift_Out, Zero and out_valid must not change.
- Throughput is one result per cycle with out_ready held high.
- Simultaneous accept at the input and drain at the output in the same cycle is legal and required.
- Reset clears all stage valid bits. Values after reset:
  - out_valid=0, Shift_Out=0, Zero=0.
  - in_ready=1 in the first cycle after reset.
- Data and sideband registers are also cleared to 0.
- Reset mid-operation discards all in-flight operands. Nothing in flight before reset ever appears at the output.
- Zero is registered with the final stage: it equals the final stage's valid bit ANDed with (result == 0). It is 0 whenever out_valid=0.
- No state machine beyond the valid pipeline.
- All arithmetic is WIDTH-bit with no overflow flag.

Test Plan (WIDTH=16):
- SLL 0x0001 by 15, then SRL 0x8000 by 15, issued back-to-back with out_ready=1 -> results 0x8000 and 0x0001 in consecutive cycles, starting 4 cycles after the first accept.
- SRA 0x8000 by 4 -> 0xF800. SRA 0x7FF0 by 4 -> 0x07FF. ROR 0x1234 by 4 -> 0x4123. ROR 0x0001 by 1 -> 0x8000.
- SLL 0xFFFF by 0 -> 0xFFFF with Zero=0. SRL 0x000F by 4 -> 0x0000 with Zero=1.
- Backpressure: stream 6 operands, drop out_ready for 3 cycles after the first result. Required response:
  - in_ready falls in the same cycles.
  - Shift_Out is held.
  - All 6 results arrive in order with none lost or duplicated.
- Reset asserted with 3 operands in flight -> next cycle out_valid=0, Shift_Out=0, in_ready=1. No stale result ever appears; a new operand issued afterwards emerges 4 cycles after its accept.
- Random regression: 10k random operands, amounts, modes and out_ready toggling. Output must match a reference model in order, and the Zero flag must be checked on every result.
